// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin bundle between the on-board master and spi_slave
interface spi_slave_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_clk, output spi_cs, output spi_mosi, input spi_miso);
    modport slave  (input spi_clk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI mode-0 responder: RX_BITS command in, TX_BITS response out
// Optional abort reporting (frame_err) enabled by macro SPI_SLAVE_ABORT_EN.
module spi_slave #(
    parameter int RX_BITS = 8,
    parameter int TX_BITS = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_slave_if.slave         spi,
    output logic [RX_BITS-1:0] rx_data,
    output logic               rx_stb,
    input  logic [TX_BITS-1:0] tx_data,
    output logic               tx_done,
    output logic               busy
`ifdef SPI_SLAVE_ABORT_EN
    ,
    output logic               frame_err
`endif
);
    localparam int MAX_BITS = (RX_BITS > TX_BITS) ? RX_BITS : TX_BITS;
    localparam int CW       = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {IDLE, RX, TX_WAIT, TX, DONE} state_t;

    logic [2:0]         sck_sync_q, sck_sync_d;
    logic [1:0]         cs_sync_q, cs_sync_d;
    logic [1:0]         mosi_sync_q, mosi_sync_d;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [RX_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [TX_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [RX_BITS-1:0] rx_data_q, rx_data_d;
    logic               rx_stb_q, rx_stb_d;
    logic               tx_done_q, tx_done_d;
    logic               busy_q, busy_d;
`ifdef SPI_SLAVE_ABORT_EN
    logic               frame_err_q, frame_err_d;
`endif

    logic sck_rise, sck_fall, cs_n, mosi;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_n     = cs_sync_q[1];
    assign mosi     = mosi_sync_q[1];
    assign cnt_inc  = cnt_q + CW'(1);

    // MISO is the MSB of the tx shift register; it is cleared whenever the line must idle low.
    assign spi.spi_miso = tx_sr_q[TX_BITS-1];
    assign rx_data      = rx_data_q;
    assign rx_stb       = rx_stb_q;
    assign tx_done      = tx_done_q;
    assign busy         = busy_q;
`ifdef SPI_SLAVE_ABORT_EN
    assign frame_err    = frame_err_q;
`endif

    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], spi.spi_clk};
        cs_sync_d   = {cs_sync_q[0], spi.spi_cs};
        mosi_sync_d = {mosi_sync_q[0], spi.spi_mosi};
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        rx_stb_d    = 1'b0;
        tx_done_d   = 1'b0;
        busy_d      = busy_q;
`ifdef SPI_SLAVE_ABORT_EN
        frame_err_d = 1'b0;
`endif
        // CS release outranks any SCK edge seen in the same cycle.
        if (state_q != IDLE && cs_n) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            tx_sr_d = '0;
`ifdef SPI_SLAVE_ABORT_EN
            frame_err_d = (state_q == RX) || (state_q == TX_WAIT) || (state_q == TX);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_n) begin
                        state_d = RX;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                RX: begin
                    if (sck_rise) begin
                        // Place each bit by position so a full frame overwrites every bit.
                        for (int i = 0; i < RX_BITS; i++) begin
                            if (cnt_q == CW'(RX_BITS - 1 - i)) rx_sr_d[i] = mosi;
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(RX_BITS)) begin
                            rx_data_d = rx_sr_d;
                            rx_stb_d  = 1'b1;
                            cnt_d     = '0;
                            state_d   = TX_WAIT;
                        end
                    end
                end
                TX_WAIT: begin
                    if (sck_fall) begin
                        tx_sr_d = tx_data;
                        state_d = TX;
                    end
                end
                TX: begin
                    if (sck_rise) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(TX_BITS)) begin
                            tx_done_d = 1'b1;
                            tx_sr_d   = '0;
                            state_d   = DONE;
                        end
                    end else if (sck_fall) begin
                        tx_sr_d[0] = 1'b0;
                        for (int i = 1; i < TX_BITS; i++) tx_sr_d[i] = tx_sr_q[i-1];
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_stb_q    <= 1'b0;
            tx_done_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_SLAVE_ABORT_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_stb_q    <= rx_stb_d;
            tx_done_q   <= tx_done_d;
            busy_q      <= busy_d;
`ifdef SPI_SLAVE_ABORT_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave (8-bit command, 8-bit response)
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_stb;
    logic [7:0] tx_data = 8'h00;
    logic       tx_done;
    logic       busy;
`ifdef SPI_SLAVE_ABORT_EN
    logic       frame_err;
`endif

    spi_slave_if bus();

    spi_slave #(.RX_BITS(8), .TX_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .spi     (bus.slave),
        .rx_data (rx_data),
        .rx_stb  (rx_stb),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .busy    (busy)
`ifdef SPI_SLAVE_ABORT_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         rx_stb_cnt = 0;
    int         tx_done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] tx_next = 8'h00;

    // Pulse counter; answers each rx_stb with the prepared response half a clk later.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_stb === 1'b1) begin
                rx_stb_cnt++;
                last_rx = rx_data;
                tx_data = tx_next;
            end
            if (tx_done === 1'b1) tx_done_cnt++;
`ifdef SPI_SLAVE_ABORT_EN
            if (frame_err === 1'b1) ferr_cnt++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_frame(input logic [31:0] mosi_w, input int nbits, input int half,
                             input bit keep_cs, output logic [31:0] miso_w);
        miso_w = '0;
        @(negedge clk);
        bus.spi_cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = mosi_w[nbits-1-i];
            repeat (half) @(negedge clk);
            bus.spi_clk = 1'b1;
            miso_w = {miso_w[30:0], bus.spi_miso};
            repeat (half) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
        repeat (half) @(negedge clk);
        if (!keep_cs) begin
            bus.spi_cs = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    logic [31:0] m;
    int          rs, td, fe;

    initial begin
        bus.spi_clk  = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_miso", {31'd0, bus.spi_miso}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_stb", {31'd0, rx_stb}, 32'd0);
        check("reset_tx_done", {31'd0, tx_done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // nominal frame
        tx_next = 8'h3C; rs = rx_stb_cnt; td = tx_done_cnt; fe = ferr_cnt;
        spi_frame(32'h0000_A500, 16, 8, 1'b0, m);
        check("nom_rx_data", {24'd0, rx_data}, 32'hA5);
        check("nom_rx_at_stb", {24'd0, last_rx}, 32'hA5);
        check("nom_rx_stb_cnt", rx_stb_cnt - rs, 1);
        check("nom_miso", m, 32'h0000_003C);
        check("nom_tx_done_cnt", tx_done_cnt - td, 1);
        check("nom_busy_after", {31'd0, busy}, 32'd0);
`ifdef SPI_SLAVE_ABORT_EN
        check("nom_no_frame_err", ferr_cnt - fe, 0);
`endif

        // back-to-back frames, one SCK period of CS high between them
        tx_next = 8'h34; rs = rx_stb_cnt; td = tx_done_cnt;
        spi_frame(32'h0000_1200, 16, 8, 1'b0, m);
        check("b2b1_rx", {24'd0, last_rx}, 32'h12);
        check("b2b1_miso", m, 32'h0000_0034);
        tx_next = 8'h78;
        spi_frame(32'h0000_5600, 16, 8, 1'b0, m);
        check("b2b2_rx", {24'd0, rx_data}, 32'h56);
        check("b2b2_miso", m, 32'h0000_0078);
        check("b2b_rx_stb_cnt", rx_stb_cnt - rs, 2);
        check("b2b_tx_done_cnt", tx_done_cnt - td, 2);

        // abort after 5 command bits
        rs = rx_stb_cnt; td = tx_done_cnt; fe = ferr_cnt;
        spi_frame(32'h0000_0016, 5, 8, 1'b0, m);
        check("abort_rx_stb_cnt", rx_stb_cnt - rs, 0);
        check("abort_tx_done_cnt", tx_done_cnt - td, 0);
        check("abort_rx_kept", {24'd0, rx_data}, 32'h56);
        check("abort_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_SLAVE_ABORT_EN
        check("abort_frame_err", ferr_cnt - fe, 1);
`endif
        tx_next = 8'h5A;
        spi_frame(32'h0000_C300, 16, 8, 1'b0, m);
        check("post_abort_rx", {24'd0, rx_data}, 32'hC3);
        check("post_abort_miso", m, 32'h0000_005A);

        // overlong frame: last 8 clocks are ignored
        tx_next = 8'hE7; td = tx_done_cnt;
        spi_frame(32'h009E_FFFF, 24, 8, 1'b0, m);
        check("long_rx", {24'd0, rx_data}, 32'h9E);
        check("long_miso", m, 32'h0000_E700);
        check("long_tx_done_cnt", tx_done_cnt - td, 1);

        // async reset after the 3rd response bit
        tx_next = 8'hB4;
        spi_frame(32'h0000_0330, 11, 8, 1'b1, m);
        check("rst_pre_miso", m, 32'h0000_0005);
        check("rst_pre_rx", {24'd0, rx_data}, 32'h66);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {30'd0, rx_stb, tx_done}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bus.spi_cs = 1'b1;
        repeat (16) @(negedge clk);
        tx_next = 8'h99;
        spi_frame(32'h0000_2D00, 16, 8, 1'b0, m);
        check("post_rst_rx", {24'd0, rx_data}, 32'h2D);
        check("post_rst_miso", m, 32'h0000_0099);

        // minimum SCK half-period of 4 clk
        tx_next = 8'h81; rs = rx_stb_cnt;
        spi_frame(32'h0000_FF00, 16, 4, 1'b0, m);
        check("min_rx", {24'd0, rx_data}, 32'hFF);
        check("min_miso", m, 32'h0000_0081);
        check("min_rx_stb_cnt", rx_stb_cnt - rs, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
